// File: rtl/rf_pkg.sv
// Register file shared constants and types.
// Imported by the encoder and the read-port top.
package rf_pkg;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int IDX_W    = 4;

  typedef logic [IDX_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] reg_word_t;
endpackage

// File: rtl/wordline_encoder_16_4.sv
// One-hot write wordline back to a register index.
// Flags exactly-one (wr_hit) and more-than-one (multi_hot).
module wordline_encoder_16_4
  import rf_pkg::*;
(
  input  logic [NUM_REGS-1:0] wl,
  output reg_idx_t            idx,
  output logic                wr_hit,
  output logic                multi_hot
);

  logic [4:0] ones;

  // OR of set-bit positions is the index when the line is one-hot
  always_comb begin
    idx  = '0;
    ones = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wl[i]) begin
        idx  = idx | reg_idx_t'(i);
        ones = ones + 5'd1;
      end
    end
    wr_hit    = (ones == 5'd1);
    multi_hot = (ones > 5'd1);
  end

endmodule

// File: rtl/regfile_read_ports.sv
// 16x16 register file: write commit, two registered read ports.
// RF_BYPASS_EN: same-edge write forwards to a matching read port.
module regfile_read_ports
  import rf_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REGS-1:0] wr_wordline,
  input  reg_word_t           wr_data,
  input  logic                rd_en,
  input  reg_idx_t            src_reg1,
  input  reg_idx_t            src_reg2,
  output reg_word_t           rd_data1,
  output reg_word_t           rd_data2,
  output logic                rd_valid,
  output logic                wl_err
);

  reg_word_t regs [NUM_REGS];
  reg_idx_t  wr_idx;
  logic      wr_hit;
  logic      multi_hot;
  logic      wr_en;
  reg_word_t rd_nxt1;
  reg_word_t rd_nxt2;

  wordline_encoder_16_4 u_enc (
    .wl        (wr_wordline),
    .idx       (wr_idx),
    .wr_hit    (wr_hit),
    .multi_hot (multi_hot)
  );

  assign wr_en = wr_hit && (wr_idx != '0);

  // Read muxes; R0 reads zero, optional write forwarding
  always_comb begin
    rd_nxt1 = '0;
    rd_nxt2 = '0;
    if (src_reg1 != '0) rd_nxt1 = regs[src_reg1];
    if (src_reg2 != '0) rd_nxt2 = regs[src_reg2];
`ifdef RF_BYPASS_EN
    if (wr_en && (wr_idx == src_reg1)) rd_nxt1 = wr_data;
    if (wr_en && (wr_idx == src_reg2)) rd_nxt2 = wr_data;
`endif
  end

  // Register array: commit single-hot writes to R1..R15
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

  // Read output registers; data holds when rd_en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data1 <= rd_nxt1;
        rd_data2 <= rd_nxt2;
      end
    end
  end

  // Sticky illegal-wordline flag
  always_ff @(posedge clk) begin
    if (rst)            wl_err <= 1'b0;
    else if (multi_hot) wl_err <= 1'b1;
  end

endmodule

// File: tb/tb_regfile_read_ports.sv
// Randomized and directed bench for regfile_read_ports.
// Reference model is a plain array updated per edge.
module tb_regfile_read_ports;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wr_wordline;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [3:0]  src_reg1;
  logic [3:0]  src_reg2;
  logic [15:0] rd_data1;
  logic [15:0] rd_data2;
  logic        rd_valid;
  logic        wl_err;

  int vectors = 0;
  int miscompares = 0;

  int          model [16];
  logic [15:0] exp_d1, exp_d2;
  logic        exp_v, exp_err;
  int          bypass_on;

  regfile_read_ports dut (
    .clk         (clk),
    .rst         (rst),
    .wr_wordline (wr_wordline),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .src_reg1    (src_reg1),
    .src_reg2    (src_reg2),
    .rd_data1    (rd_data1),
    .rd_data2    (rd_data2),
    .rd_valid    (rd_valid),
    .wl_err      (wl_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_read(int src, int ones, int k);
    if (src == 0) return 16'h0;
    if (bypass_on != 0 && ones == 1 && k == src) return wr_data;
    return 16'(model[src]);
  endfunction

  // Advance one edge, updating the model from the current inputs
  task automatic tick();
    int ones;
    int k;
    ones = $countones(wr_wordline);
    k = 0;
    for (int i = 0; i < 16; i++) if (wr_wordline[i]) k = i;
    if (rst) begin
      for (int i = 0; i < 16; i++) model[i] = 0;
      exp_d1 = 16'h0;
      exp_d2 = 16'h0;
      exp_v = 1'b0;
      exp_err = 1'b0;
    end else begin
      exp_v = rd_en;
      if (rd_en) begin
        exp_d1 = model_read(int'(src_reg1), ones, k);
        exp_d2 = model_read(int'(src_reg2), ones, k);
      end
      if (ones > 1) exp_err = 1'b1;
      else if (ones == 1 && k != 0) model[k] = int'(wr_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0;
    wr_wordline = 16'h0;
    wr_data = 16'h0;
    rd_en = 1'b0;
    src_reg1 = 4'd0;
    src_reg2 = 4'd0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    rd_en = 1'b1;
    tick();
    vectors++;
    if (rd_data1 !== 16'h0 || rd_data2 !== 16'h0 ||
        rd_valid !== 1'b0 || wl_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state d1=%h d2=%h v=%b err=%b req 0/0/0/0",
               rd_data1, rd_data2, rd_valid, wl_err);
    end
    idle();
    rd_en = 1'b1;
    src_reg1 = 4'd3;
    src_reg2 = 4'd7;
    tick();
    vectors++;
    if (rd_data1 !== 16'h0 || rd_data2 !== 16'h0 || rd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL first_read d1=%h d2=%h v=%b req 0000/0000/1",
               rd_data1, rd_data2, rd_valid);
    end
  endtask

  task automatic test_write_read();
    idle();
    wr_wordline = 16'h0008;
    wr_data = 16'hBEEF;
    tick();
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL valid_low got=%b req=0", rd_valid);
    end
    idle();
    rd_en = 1'b1;
    src_reg1 = 4'd3;
    src_reg2 = 4'd3;
    tick();
    vectors++;
    if (rd_data1 !== 16'hBEEF || rd_data2 !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL write_read d1=%h d2=%h req BEEF", rd_data1, rd_data2);
    end
  endtask

  task automatic test_r0();
    idle();
    wr_wordline = 16'h0001;
    wr_data = 16'h1234;
    tick();
    idle();
    rd_en = 1'b1;
    tick();
    vectors++;
    if (rd_data1 !== 16'h0 || wl_err !== 1'b0) begin
      miscompares++;
      $display("FAIL r0_write d1=%h err=%b req 0000/0", rd_data1, wl_err);
    end
  endtask

  task automatic test_multihot();
    idle();
    wr_wordline = 16'h0030;
    wr_data = 16'hFFFF;
    tick();
    vectors++;
    if (wl_err !== 1'b1) begin
      miscompares++;
      $display("FAIL multihot_err got=%b req=1", wl_err);
    end
    idle();
    rd_en = 1'b1;
    src_reg1 = 4'd4;
    src_reg2 = 4'd5;
    tick();
    vectors++;
    if (rd_data1 !== 16'h0 || rd_data2 !== 16'h0 || wl_err !== 1'b1) begin
      miscompares++;
      $display("FAIL multihot_nowrite d1=%h d2=%h err=%b req 0/0/1",
               rd_data1, rd_data2, wl_err);
    end
    idle();
    rst = 1'b1;
    tick();
    vectors++;
    if (wl_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear got=%b req=0", wl_err);
    end
  endtask

  task automatic test_bypass();
    logic [15:0] req;
    idle();
    wr_wordline = 16'h0020;
    wr_data = 16'h0011;
    tick();
    idle();
    wr_wordline = 16'h0020;
    wr_data = 16'h00AA;
    rd_en = 1'b1;
    src_reg1 = 4'd5;
    src_reg2 = 4'd5;
    tick();
    req = (bypass_on != 0) ? 16'h00AA : 16'h0011;
    vectors++;
    if (rd_data1 !== req || rd_data2 !== req) begin
      miscompares++;
      $display("FAIL same_edge d1=%h d2=%h req %h", rd_data1, rd_data2, req);
    end
    idle();
    rd_en = 1'b1;
    src_reg1 = 4'd5;
    tick();
    vectors++;
    if (rd_data1 !== 16'h00AA) begin
      miscompares++;
      $display("FAIL after_write d1=%h req 00AA", rd_data1);
    end
  endtask

  task automatic test_rst_read();
    idle();
    wr_wordline = 16'h0004;
    wr_data = 16'h5555;
    tick();
    idle();
    rst = 1'b1;
    rd_en = 1'b1;
    src_reg1 = 4'd2;
    src_reg2 = 4'd2;
    tick();
    vectors++;
    if (rd_data1 !== 16'h0 || rd_data2 !== 16'h0 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_read d1=%h d2=%h v=%b req 0/0/0",
               rd_data1, rd_data2, rd_valid);
    end
    idle();
    rd_en = 1'b1;
    src_reg1 = 4'd2;
    tick();
    vectors++;
    if (rd_data1 !== 16'h0 || rd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL post_rst_read d1=%h v=%b req 0000/1", rd_data1, rd_valid);
    end
  endtask

  task automatic test_random();
    int sel;
    int k;
    for (int n = 0; n < 400; n++) begin
      idle();
      sel = int'($urandom_range(0, 99));
      k = int'($urandom_range(0, 15));
      if (sel < 70) wr_wordline = 16'(1) << k;
      else if (sel < 97) wr_wordline = 16'h0;
      else wr_wordline = 16'(1) << k | 16'(1) << ((k + 3) % 16);
      wr_data = 16'($urandom);
      rd_en = ($urandom_range(0, 3) != 0);
      src_reg1 = 4'($urandom);
      src_reg2 = 4'($urandom);
      if ($urandom_range(0, 3) == 0) src_reg1 = 4'(k);
      if ($urandom_range(0, 3) == 0) src_reg2 = 4'(k);
      rst = ($urandom_range(0, 99) == 0);
      tick();
      vectors++;
      if (rd_data1 !== exp_d1 || rd_data2 !== exp_d2 ||
          rd_valid !== exp_v || wl_err !== exp_err) begin
        miscompares++;
        $display("FAIL rand[%0d] d1=%h/%h d2=%h/%h v=%b/%b err=%b/%b", n,
                 rd_data1, exp_d1, rd_data2, exp_d2,
                 rd_valid, exp_v, wl_err, exp_err);
      end
    end
  endtask

  initial begin
`ifdef RF_BYPASS_EN
    bypass_on = 1;
`else
    bypass_on = 0;
`endif
    for (int i = 0; i < 16; i++) model[i] = 0;
    exp_d1 = 16'h0;
    exp_d2 = 16'h0;
    exp_v = 1'b0;
    exp_err = 1'b0;
    idle();
    #2;
    test_reset();
    test_write_read();
    test_r0();
    test_multihot();
    test_bypass();
    test_rst_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
